// File: rtl/outer_ebi_ctrl_if.sv
// Bus bundle between the outer EBI controller and its surroundings
// (pad transceiver, system request/response channel, snoop channel).
//   master : the controller (drives transceiver control, frames and handshakes)
//   slave  : the environment (transceiver status, received body, system and
//            snoop agents)
interface outer_ebi_ctrl_if #(
  parameter int PADDR_WIDTH      = 32,
  parameter int CACHELINE_LENGTH = 512,
  parameter int SEND_LEN         = 608,
  parameter int RECV_LEN         = 560
);
  // transceiver status / control
  logic                        trx_rcv_start;
  logic                        trx_rcv_done;
  logic                        trx_send_done;
  logic [3:0]                  opcode;
  logic                        is_counter_reload;
  logic                        is_counter_ena;
  logic                        is_rd_rcv;
  logic                        is_send_mode;
  logic [RECV_LEN-1:0]         resp_data;
  logic [SEND_LEN-1:0]         send_data;
  // transceiver-decoded flags of the received frame
  logic                        req_is_read;
  logic                        w_has_data;
  logic                        snp_resp_hasdata;
  // system request
  logic                        sys_req_valid;
  logic                        sys_req_ready;
  logic                        sys_req_is_read;
  logic                        sys_req_has_data;
  logic [RECV_LEN-1:0]         sys_req_payload;
  // system read response
  logic                        sys_rresp_valid;
  logic                        sys_rresp_ready;
  logic [CACHELINE_LENGTH-1:0] sys_rresp_data;
  logic [1:0]                  sys_rresp_mesi;
  // snoop request
  logic                        snp_req_valid;
  logic                        snp_req_ready;
  logic [PADDR_WIDTH-1:0]      snp_req_addr;
  logic [3:0]                  snp_req_type;
  // snoop response
  logic                        snp_resp_valid;
  logic                        snp_resp_ready;
  logic                        snp_resp_has_data;
  logic [RECV_LEN-1:0]         snp_resp_payload;

  modport master (
    input  trx_rcv_start, trx_rcv_done, trx_send_done, resp_data,
           req_is_read, w_has_data, snp_resp_hasdata,
           sys_req_ready, sys_rresp_valid, sys_rresp_data, sys_rresp_mesi,
           snp_req_valid, snp_req_addr, snp_req_type, snp_resp_ready,
    output opcode, is_counter_reload, is_counter_ena, is_rd_rcv, is_send_mode,
           send_data, sys_req_valid, sys_req_is_read, sys_req_has_data,
           sys_req_payload, sys_rresp_ready, snp_req_ready, snp_resp_valid,
           snp_resp_has_data, snp_resp_payload
  );

  modport slave (
    output trx_rcv_start, trx_rcv_done, trx_send_done, resp_data,
           req_is_read, w_has_data, snp_resp_hasdata,
           sys_req_ready, sys_rresp_valid, sys_rresp_data, sys_rresp_mesi,
           snp_req_valid, snp_req_addr, snp_req_type, snp_resp_ready,
    input  opcode, is_counter_reload, is_counter_ena, is_rd_rcv, is_send_mode,
           send_data, sys_req_valid, sys_req_is_read, sys_req_has_data,
           sys_req_payload, sys_rresp_ready, snp_req_ready, snp_resp_valid,
           snp_resp_has_data, snp_resp_payload
  );
endinterface

// File: rtl/outer_ebi_ctrl.sv
// Outer EBI controller: sequences the pad transceiver through receive and
// send phases, turns received frames into system requests or snoop
// responses, and builds RD_RESP / SNP / ACK transmit frames.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - outer_ebi_ctrl_if.master: transceiver status/control, frame data,
//          system request/read-response and snoop request/response channels
//
// state      | meaning
// IDLE       | waiting for a received frame or a snoop to forward
// RCV_OP     | reload transceiver counter for the incoming frame
// RCV_BODY   | counting received words
// RCV_LAST   | last received word; body captured on exit
// DISPATCH   | offering the received frame as sys request or snoop response
// WAIT_RRESP | waiting for the system read data
// SEND_LOAD  | reload transceiver counter for the outgoing frame
// SEND       | shifting the frame out until the transceiver is done
module outer_ebi_ctrl #(
  parameter int PADDR_WIDTH      = 32,
  parameter int CACHELINE_LENGTH = 512,
  parameter int EBI_WIDTH        = 16,
  parameter int SEND_LEN         = 608,
  parameter int RECV_LEN         = 560
) (
  input  logic             clk,
  input  logic             rst,
  outer_ebi_ctrl_if.master bus
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RCV_OP     = 3'd1;
  localparam logic [2:0] RCV_BODY   = 3'd2;
  localparam logic [2:0] RCV_LAST   = 3'd3;
  localparam logic [2:0] DISPATCH   = 3'd4;
  localparam logic [2:0] WAIT_RRESP = 3'd5;
  localparam logic [2:0] SEND_LOAD  = 3'd6;
  localparam logic [2:0] SEND       = 3'd7;

  localparam logic [3:0] OP_SNP     = 4'h6;
  localparam logic [3:0] OP_RD_RESP = 4'h7;
  localparam logic [3:0] OP_ACK     = 4'hF;

  localparam int LINE_WORDS = CACHELINE_LENGTH / EBI_WIDTH;
  localparam int ADDR_WORDS = PADDR_WIDTH / EBI_WIDTH;

  logic [2:0]          state, state_nxt;
  logic                snp_outstanding;
  logic [3:0]          opcode_q;
  logic [RECV_LEN-1:0] payload_q;
  logic [SEND_LEN-1:0] send_data_q;
  logic                is_read_q;
  logic                has_data_q;
  logic                snp_hasdata_q;

  logic                snp_accept;
  logic                sys_hs;
  logic                snp_hs;
  logic                rresp_hs;
  logic                send_fin;
  logic [SEND_LEN-1:0] rd_frame;
  logic [SEND_LEN-1:0] snp_frame;

  // Start word, opcode word, everything above left all-ones.
  function automatic logic [SEND_LEN-1:0] frame_hdr(input logic [3:0] op);
    logic [SEND_LEN-1:0] f;
    f = '1;
    f[EBI_WIDTH-1:0] = '0;
    f[EBI_WIDTH +: EBI_WIDTH] = {{(EBI_WIDTH-4){1'b0}}, op};
    return f;
  endfunction

  // A pending receive always wins over a snoop; reset also blocks acceptance
  // since this ready is combinational on the request inputs.
  assign snp_accept = (state == IDLE) && !rst && !bus.trx_rcv_start &&
                      bus.snp_req_valid && !snp_outstanding;
  assign sys_hs     = (state == DISPATCH) && !snp_outstanding && bus.sys_req_ready;
  assign snp_hs     = (state == DISPATCH) && snp_outstanding && bus.snp_resp_ready;
  assign rresp_hs   = (state == WAIT_RRESP) && bus.sys_rresp_valid;
  assign send_fin   = (state == SEND) && bus.trx_send_done;

  always_comb begin
    rd_frame = frame_hdr(OP_RD_RESP);
    rd_frame[2*EBI_WIDTH +: CACHELINE_LENGTH] = bus.sys_rresp_data;
    rd_frame[(2+LINE_WORDS)*EBI_WIDTH +: EBI_WIDTH] =
      {{(EBI_WIDTH-2){1'b0}}, bus.sys_rresp_mesi};
    snp_frame = frame_hdr(OP_SNP);
    snp_frame[2*EBI_WIDTH +: PADDR_WIDTH] = bus.snp_req_addr;
    snp_frame[(2+ADDR_WORDS)*EBI_WIDTH +: EBI_WIDTH] =
      {{(EBI_WIDTH-4){1'b0}}, bus.snp_req_type};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.trx_rcv_start) state_nxt = RCV_OP;
        else if (snp_accept)   state_nxt = SEND_LOAD;
      end
      RCV_OP:   state_nxt = RCV_BODY;
      RCV_BODY: if (bus.trx_rcv_done) state_nxt = RCV_LAST;
      RCV_LAST: state_nxt = DISPATCH;
      DISPATCH: begin
        if (snp_hs)      state_nxt = IDLE;
        else if (sys_hs) state_nxt = is_read_q ? WAIT_RRESP : SEND_LOAD;
      end
      WAIT_RRESP: if (rresp_hs) state_nxt = SEND_LOAD;
      SEND_LOAD:  state_nxt = SEND;
      SEND:       if (send_fin) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // The built frame register doubles as the latched snoop address/type.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      snp_outstanding <= 1'b0;
      opcode_q        <= 4'h0;
      payload_q       <= '0;
      send_data_q     <= '1;
      is_read_q       <= 1'b0;
      has_data_q      <= 1'b0;
      snp_hasdata_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RCV_LAST) begin
        payload_q     <= bus.resp_data;
        is_read_q     <= bus.req_is_read;
        has_data_q    <= bus.w_has_data;
        snp_hasdata_q <= bus.snp_resp_hasdata;
      end
      if (snp_accept) begin
        opcode_q    <= OP_SNP;
        send_data_q <= snp_frame;
      end else if (rresp_hs) begin
        opcode_q    <= OP_RD_RESP;
        send_data_q <= rd_frame;
      end else if (sys_hs && !is_read_q) begin
        opcode_q    <= OP_ACK;
        send_data_q <= frame_hdr(OP_ACK);
      end
      if (send_fin && (opcode_q == OP_SNP)) snp_outstanding <= 1'b1;
      else if (snp_hs)                      snp_outstanding <= 1'b0;
    end
  end

  assign bus.is_counter_reload = (state == RCV_OP) || (state == SEND_LOAD);
  assign bus.is_counter_ena    = (state == RCV_BODY) || (state == RCV_LAST) ||
                                 (state == SEND);
  assign bus.is_rd_rcv         = (state == RCV_BODY) || (state == RCV_LAST);
  assign bus.is_send_mode      = (state == SEND);
  assign bus.opcode            = opcode_q;
  assign bus.send_data         = send_data_q;

  assign bus.sys_req_valid     = (state == DISPATCH) && !snp_outstanding;
  assign bus.sys_req_is_read   = is_read_q;
  assign bus.sys_req_has_data  = has_data_q;
  assign bus.sys_req_payload   = payload_q;
  assign bus.sys_rresp_ready   = (state == WAIT_RRESP);
  assign bus.snp_req_ready     = snp_accept;
  assign bus.snp_resp_valid    = (state == DISPATCH) && snp_outstanding;
  assign bus.snp_resp_has_data = snp_hasdata_q;
  assign bus.snp_resp_payload  = payload_q;

endmodule

// File: tb/tb_outer_ebi_ctrl.sv
// Directed bench for outer_ebi_ctrl. A transaction-level model (expected
// opcode, frame built word by word, payload, and which handshake outputs
// should be up) is updated by the stimulus tasks; one negedge process
// compares the DUT against it every cycle. Tasks add literal checks on the
// counter/receive/send control pulses and a few hand-computed frame words.
module tb_outer_ebi_ctrl;
  localparam int PADDR_WIDTH      = 32;
  localparam int CACHELINE_LENGTH = 512;
  localparam int EBI_WIDTH        = 16;
  localparam int SEND_LEN         = 608;
  localparam int RECV_LEN         = 560;
  localparam int NWORDS           = SEND_LEN / 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  outer_ebi_ctrl_if #(.PADDR_WIDTH(PADDR_WIDTH), .CACHELINE_LENGTH(CACHELINE_LENGTH),
                      .SEND_LEN(SEND_LEN), .RECV_LEN(RECV_LEN)) bus ();

  outer_ebi_ctrl #(.PADDR_WIDTH(PADDR_WIDTH), .CACHELINE_LENGTH(CACHELINE_LENGTH),
                   .EBI_WIDTH(EBI_WIDTH), .SEND_LEN(SEND_LEN), .RECV_LEN(RECV_LEN))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [SEND_LEN-1:0] m_frame;
  logic [3:0]          m_opcode;
  logic [RECV_LEN-1:0] m_payload;
  bit m_on, m_sys_req, m_is_read, m_has_data, m_snp_resp, m_snp_has, m_rresp_rdy, m_send_mode;

  logic [RECV_LEN-1:0]         body_a, body_b, body_c, body_d;
  logic [CACHELINE_LENGTH-1:0] line_a, line_b;

  task automatic chk(input string name, input logic [SEND_LEN-1:0] act,
                     input logic [SEND_LEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [SEND_LEN-1:0] f, input int i);
    return f[16*i +: 16];
  endfunction

  // Frame assembled as a list of 16-bit pad words, then packed low word first.
  function automatic logic [SEND_LEN-1:0] mk_frame(input logic [3:0] op,
      input logic [CACHELINE_LENGTH-1:0] line, input logic [1:0] mesi,
      input logic [31:0] addr, input logic [3:0] typ);
    logic [15:0] w [NWORDS];
    logic [SEND_LEN-1:0] f;
    for (int i = 0; i < NWORDS; i++) w[i] = 16'hFFFF;
    w[0] = 16'h0000;
    w[1] = {12'h000, op};
    if (op == 4'h7) begin
      for (int i = 0; i < 32; i++) w[2+i] = line[16*i +: 16];
      w[34] = {14'h0000, mesi};
    end else if (op == 4'h6) begin
      w[2] = addr[15:0];
      w[3] = addr[31:16];
      w[4] = {12'h000, typ};
    end
    for (int i = 0; i < NWORDS; i++) f[16*i +: 16] = w[i];
    return f;
  endfunction

  always @(negedge clk) begin
    if (m_on) begin
      chk("opcode", bus.opcode, m_opcode);
      chk("send_data", bus.send_data, m_frame);
      chk("sys_req_payload", bus.sys_req_payload, m_payload);
      chk("snp_resp_payload", bus.snp_resp_payload, m_payload);
      chk("sys_req_valid", bus.sys_req_valid, m_sys_req);
      chk("snp_resp_valid", bus.snp_resp_valid, m_snp_resp);
      chk("sys_rresp_ready", bus.sys_rresp_ready, m_rresp_rdy);
      chk("is_send_mode", bus.is_send_mode, m_send_mode);
      if (m_sys_req) begin
        chk("sys_req_is_read", bus.sys_req_is_read, m_is_read);
        chk("sys_req_has_data", bus.sys_req_has_data, m_has_data);
      end
      if (m_snp_resp) chk("snp_resp_has_data", bus.snp_resp_has_data, m_snp_has);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.trx_rcv_start = 0; bus.trx_rcv_done = 0; bus.trx_send_done = 0;
    bus.resp_data = '0; bus.req_is_read = 0; bus.w_has_data = 0; bus.snp_resp_hasdata = 0;
    bus.sys_req_ready = 0; bus.sys_rresp_valid = 0; bus.sys_rresp_data = '0;
    bus.sys_rresp_mesi = 2'b00; bus.snp_req_valid = 0; bus.snp_req_addr = '0;
    bus.snp_req_type = 4'h0; bus.snp_resp_ready = 0;
  endtask

  task automatic do_reset(input bit snp_poke);
    rst = 1'b1;
    idle_inputs();
    bus.snp_req_valid = snp_poke;
    tick();
    m_opcode = 4'h0; m_payload = '0; m_frame = '1;
    m_sys_req = 0; m_snp_resp = 0; m_rresp_rdy = 0; m_send_mode = 0;
    m_on = 1;
    chk("rst_reload", bus.is_counter_reload, 1'b0);
    chk("rst_ena", bus.is_counter_ena, 1'b0);
    chk("rst_rd_rcv", bus.is_rd_rcv, 1'b0);
    chk("rst_send_mode", bus.is_send_mode, 1'b0);
    chk("rst_sys_req_valid", bus.sys_req_valid, 1'b0);
    chk("rst_snp_resp_valid", bus.snp_resp_valid, 1'b0);
    chk("rst_rresp_ready", bus.sys_rresp_ready, 1'b0);
    chk("rst_snp_req_ready", bus.snp_req_ready, 1'b0);
    chk("rst_opcode_lit", bus.opcode, 4'h0);
    chk("rst_send_data_lit", bus.send_data, {SEND_LEN{1'b1}});
    chk("rst_payload_lit", bus.sys_req_payload, {RECV_LEN{1'b0}});
    tick();
    bus.snp_req_valid = 0;
    rst = 1'b0;
  endtask

  // Called in IDLE; returns one cycle into DISPATCH.
  task automatic do_rcv(input logic [RECV_LEN-1:0] body, input bit rd, input bit wd,
                        input bit sh, input int body_cycles);
    bus.resp_data = body; bus.req_is_read = rd; bus.w_has_data = wd;
    bus.snp_resp_hasdata = sh;
    bus.trx_rcv_start = 1;
    #1 chk("rcv_snp_ready", bus.snp_req_ready, 1'b0);
    tick();
    bus.trx_rcv_start = 0;
    chk("rcv_op_reload", bus.is_counter_reload, 1'b1);
    chk("rcv_op_ena", bus.is_counter_ena, 1'b0);
    tick();
    chk("rcv_body_reload", bus.is_counter_reload, 1'b0);
    chk("rcv_body_ena", bus.is_counter_ena, 1'b1);
    chk("rcv_body_rd_rcv", bus.is_rd_rcv, 1'b1);
    repeat (body_cycles) tick();
    bus.trx_rcv_done = 1;
    tick();
    bus.trx_rcv_done = 0;
    chk("rcv_last_ena", bus.is_counter_ena, 1'b1);
    chk("rcv_last_rd_rcv", bus.is_rd_rcv, 1'b1);
    tick();
    m_payload = body;
    chk("dispatch_ena", bus.is_counter_ena, 1'b0);
    chk("dispatch_rd_rcv", bus.is_rd_rcv, 1'b0);
  endtask

  task automatic do_sys_dispatch(input bit rd, input bit wd, input int delay);
    m_sys_req = 1; m_is_read = rd; m_has_data = wd;
    repeat (delay) tick();
    bus.sys_req_ready = 1;
    tick();
    bus.sys_req_ready = 0;
    m_sys_req = 0;
    if (rd) m_rresp_rdy = 1;
    else begin
      m_opcode = 4'hF;
      m_frame  = mk_frame(4'hF, '0, 2'b00, 32'h0, 4'h0);
    end
  endtask

  task automatic do_rresp(input logic [CACHELINE_LENGTH-1:0] line, input logic [1:0] mesi,
                          input int delay);
    repeat (delay) tick();
    bus.sys_rresp_data = line; bus.sys_rresp_mesi = mesi; bus.sys_rresp_valid = 1;
    tick();
    bus.sys_rresp_valid = 0;
    m_rresp_rdy = 0;
    m_opcode = 4'h7;
    m_frame  = mk_frame(4'h7, line, mesi, 32'h0, 4'h0);
  endtask

  task automatic do_snp_req(input logic [31:0] addr, input logic [3:0] typ);
    bus.snp_req_addr = addr; bus.snp_req_type = typ; bus.snp_req_valid = 1;
    #1 chk("snp_req_ready", bus.snp_req_ready, 1'b1);
    tick();
    bus.snp_req_valid = 0;
    m_opcode = 4'h6;
    m_frame  = mk_frame(4'h6, '0, 2'b00, addr, typ);
  endtask

  task automatic do_snp_dispatch(input bit sh, input int delay);
    m_snp_resp = 1; m_snp_has = sh;
    repeat (delay) tick();
    bus.snp_resp_ready = 1;
    tick();
    bus.snp_resp_ready = 0;
    m_snp_resp = 0;
  endtask

  // Called one cycle into SEND_LOAD; returns one cycle into IDLE.
  task automatic do_send(input int cycles, input bit poke_start);
    chk("send_load_reload", bus.is_counter_reload, 1'b1);
    tick();
    m_send_mode = 1;
    chk("send_reload", bus.is_counter_reload, 1'b0);
    chk("send_ena", bus.is_counter_ena, 1'b1);
    chk("send_rd_rcv", bus.is_rd_rcv, 1'b0);
    if (poke_start) bus.trx_rcv_start = 1;
    repeat (cycles) tick();
    bus.trx_rcv_start = 0;
    bus.trx_send_done = 1;
    tick();
    bus.trx_send_done = 0;
    m_send_mode = 0;
    chk("send_idle_ena", bus.is_counter_ena, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    body_a = {35{16'hBEEF}};
    body_b = {35{16'h1234}};
    body_c = {35{16'h0F0F}};
    body_d = {35{16'h5A5A}};
    line_a = {64{8'hA5}};
    for (int i = 0; i < 32; i++) line_b[16*i +: 16] = 16'h0100 + 16'(i);
    idle_inputs();
    do_reset(1'b1);

    // read
    do_rcv(body_a, 1, 0, 0, 3);
    do_sys_dispatch(1, 0, 2);
    do_rresp(line_a, 2'b10, 1);
    chk("rd_opcode_lit", bus.opcode, 4'h7);
    chk("rd_word1_lit", word_of(bus.send_data, 1), 16'h0007);
    chk("rd_word2_lit", word_of(bus.send_data, 2), 16'hA5A5);
    chk("rd_word34_lit", word_of(bus.send_data, 34), 16'h0002);
    chk("rd_word35_lit", word_of(bus.send_data, 35), 16'hFFFF);
    do_send(4, 0);

    // write with data, slow ready, receive start poked during SEND
    do_rcv(body_b, 0, 1, 0, 2);
    do_sys_dispatch(0, 1, 5);
    chk("ack_opcode_lit", bus.opcode, 4'hF);
    chk("ack_word0_lit", word_of(bus.send_data, 0), 16'h0000);
    chk("ack_word1_lit", word_of(bus.send_data, 1), 16'h000F);
    chk("ack_word2_lit", word_of(bus.send_data, 2), 16'hFFFF);
    do_send(2, 1);
    tick();
    chk("no_queued_rcv", bus.is_counter_reload, 1'b0);

    // snoop out, second snoop blocked, next frame becomes snoop response
    do_snp_req(32'h8000_1040, 4'h3);
    chk("snp_opcode_lit", bus.opcode, 4'h6);
    chk("snp_word2_lit", word_of(bus.send_data, 2), 16'h1040);
    chk("snp_word3_lit", word_of(bus.send_data, 3), 16'h8000);
    chk("snp_word4_lit", word_of(bus.send_data, 4), 16'h0003);
    chk("snp_word5_lit", word_of(bus.send_data, 5), 16'hFFFF);
    do_send(3, 0);
    bus.snp_req_valid = 1;
    #1 chk("snp_blocked_ready0", bus.snp_req_ready, 1'b0);
    tick();
    chk("snp_blocked_ready1", bus.snp_req_ready, 1'b0);
    bus.snp_req_valid = 0;
    do_rcv(body_c, 1, 0, 1, 1);
    do_snp_dispatch(1, 3);

    // collision: receive wins, snoop follows afterwards
    bus.snp_req_addr = 32'h1234_5678; bus.snp_req_type = 4'h5; bus.snp_req_valid = 1;
    do_rcv(body_d, 0, 0, 0, 0);
    do_sys_dispatch(0, 0, 0);
    do_send(1, 0);
    do_snp_req(32'h1234_5678, 4'h5);
    chk("col_word2_lit", word_of(bus.send_data, 2), 16'h5678);
    do_send(1, 0);
    do_rcv(body_a, 0, 0, 0, 0);
    do_snp_dispatch(0, 0);

    // reset during RCV_BODY
    bus.resp_data = body_b; bus.trx_rcv_start = 1;
    tick();
    bus.trx_rcv_start = 0;
    tick();
    tick();
    chk("pre_rst_rd_rcv", bus.is_rd_rcv, 1'b1);
    do_reset(1'b0);
    do_rcv(body_c, 0, 1, 0, 1);
    do_sys_dispatch(0, 1, 1);
    do_send(2, 0);

    // reset during SEND, then a read with distinct words
    do_rcv(body_d, 1, 0, 0, 0);
    do_sys_dispatch(1, 0, 0);
    do_rresp(line_a, 2'b11, 0);
    tick();
    m_send_mode = 1;
    tick();
    tick();
    do_reset(1'b0);
    do_rcv(body_b, 1, 1, 0, 2);
    do_sys_dispatch(1, 1, 1);
    do_rresp(line_b, 2'b01, 2);
    chk("rd2_word2_lit", word_of(bus.send_data, 2), 16'h0100);
    chk("rd2_word33_lit", word_of(bus.send_data, 33), 16'h011F);
    chk("rd2_word34_lit", word_of(bus.send_data, 34), 16'h0001);
    do_send(2, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
